muldiv: RTL

Multi-cycle integer multiply/divide unit owning the architectural HI/LO register pair. Sits beside the single-cycle ALU in the execute stage: it consumes the same signed 32-bit operand pair, runs MULT/MULTU/DIV/DIVU iteratively over a start/busy/done handshake, and services MTHI/MTLO writes. The control unit stalls the pipeline on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv.sv | 95 +++++++++
 1 files changed

// File: rtl/muldiv.sv
// muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH:0]         r_rem;
    logic [WIDTH-1:0]       r_opd, r_hi, r_lo;
    logic                   r_div, r_neg_q, r_neg_r, r_busy, r_done;
    logic                   w_go, w_last, w_sgn;
    logic [WIDTH-1:0]       w_ma, w_mb, w_remv;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH+1:0]       w_sh, w_diff;
    logic [2*WIDTH-1:0]     w_prod;
    assign w_go   = r_state == IDLE && i_start && !i_op[2];
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_sgn  = !i_op[0];
    assign w_ma   = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mb   = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    // multiply step: add multiplicand into the upper half, keep the carry
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
    // divide step: shift next dividend bit into the partial remainder, trial subtract
    assign w_sh   = {r_rem, r_acc[WIDTH-1]};
    assign w_diff = w_sh - {2'b0, r_opd};
    // low bits of a 2W negation depend only on low bits, so the quotient reuses this path
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_remv = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;
    // state register plus registered busy/done handshake
    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? IDLE : w_next;
        r_busy  <= !i_rst && w_next != IDLE;
        r_done  <= !i_rst && r_state == FIX;
    end
    // next state: CALC runs exactly WIDTH iterations before the sign fix-up
    always_comb begin
        w_next = IDLE;
        w_next = r_state == IDLE ? (w_go ? CALC : IDLE) :
                 r_state == CALC ? (w_last ? FIX : CALC) : IDLE;
    end
    // datapath: operand latch, shift-add / restoring divide, result write-back
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_opd   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_go) begin
                r_cnt   <= '0;
                r_div   <= i_op[1];
                r_rem   <= '0;
                r_opd   <= i_op[1] ? w_mb : w_ma;
                r_acc   <= {{WIDTH{1'b0}}, i_op[1] ? w_ma : w_mb};
                r_neg_q <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]) && !(i_op[1] && i_b == '0);
                r_neg_r <= w_sgn && i_a[WIDTH-1];
            end
            if (i_start && i_op == 3'd4) r_hi <= i_a;
            if (i_start && i_op == 3'd5) r_lo <= i_a;
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
                r_rem              <= w_diff[WIDTH+1] ? w_sh[WIDTH:0] : w_diff[WIDTH:0];
                r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], !w_diff[WIDTH+1]};
            end else begin
                r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= r_div ? w_remv : w_prod[2*WIDTH-1:WIDTH];
        end
    end
endmodule
